if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter and issues word requests to the instruction memory over a req/ready handshake, which tolerates wait states. It presents each fetched (pc, instruction) pair to the IF/ID pipeline register. It honours the pipeline `stall` vector, delayed-branch redirects from ID, and exception flushes, and raises a stall request while memory is slow.

---
 rtl/if_fetch.sv | 172 +++++++++++++++++
 tb/tb_if_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and talks to instruction memory over a req/ready handshake.
// It handles delay-slot branches, exception flushes that kill in-flight requests, and IF stalls.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ready,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] drain_addr_r, drain_addr_nxt_s;
    logic [31:0] bt_r, bt_nxt_s;
    logic [31:0] buf_r, buf_nxt_s;
    logic        bp_r, bp_nxt_s;
    logic        branch_now_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;
    logic [31:0] flush_pc_s;
    logic        port_unused_s;

    assign port_unused_s = ^{stall[5:1], branch_target_address_i[1:0], new_pc[1:0]};

    // Sequential-successor computation; a branch arriving this cycle already steers the next PC.
    always_comb begin
        branch_now_s = branch_flag_i & ~flush & (state_r != ST_RST);
        target_s     = branch_now_s ? {branch_target_address_i[31:2], 2'b00} : bt_r;
        next_pc_s    = (bp_r | branch_now_s) ? target_s : (pc_r + STEP);
        flush_pc_s   = {new_pc[31:2], 2'b00};
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_RST;
            pc_r         <= {RESET_PC[31:2], 2'b00};
            drain_addr_r <= {RESET_PC[31:2], 2'b00};
            bt_r         <= 32'h0000_0000;
            buf_r        <= 32'h0000_0000;
            bp_r         <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            drain_addr_r <= drain_addr_nxt_s;
            bt_r         <= bt_nxt_s;
            buf_r        <= buf_nxt_s;
            bp_r         <= bp_nxt_s;
        end
    end

    // Next-state logic; flush overrides every other event outside RST.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        drain_addr_nxt_s = drain_addr_r;
        bt_nxt_s         = target_s;
        buf_nxt_s        = buf_r;
        bp_nxt_s         = bp_r | branch_now_s;
        case (state_r)
            ST_RST: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (flush) begin
                    pc_nxt_s  = flush_pc_s;
                    bp_nxt_s  = 1'b0;
                    buf_nxt_s = 32'h0000_0000;
                    if (inst_ready) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s      = ST_DRAIN;
                        drain_addr_nxt_s = pc_r;
                    end
                end else if (inst_ready && stall[0]) begin
                    buf_nxt_s   = inst_rdata;
                    state_nxt_s = ST_HOLD;
                end else if (inst_ready) begin
                    pc_nxt_s = next_pc_s;
                    bp_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_nxt_s    = flush_pc_s;
                    bp_nxt_s    = 1'b0;
                    buf_nxt_s   = 32'h0000_0000;
                    state_nxt_s = ST_FETCH;
                end else if (!stall[0]) begin
                    pc_nxt_s    = next_pc_s;
                    bp_nxt_s    = 1'b0;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    pc_nxt_s  = flush_pc_s;
                    bp_nxt_s  = 1'b0;
                    buf_nxt_s = 32'h0000_0000;
                end else begin
                    pc_nxt_s = pc_r;
                end
                // The killed request's data is thrown away on its ready.
                if (inst_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_RST;
            end
        endcase
    end

    // Memory request and IF/ID presentation.
    always_comb begin
        inst_req    = 1'b0;
        inst_addr   = pc_r;
        if_pc       = pc_r;
        if_inst     = 32'h0000_0000;
        stallreq_if = 1'b0;
        case (state_r)
            ST_FETCH: begin
                inst_req    = 1'b1;
                stallreq_if = ~inst_ready;
                if (inst_ready && !flush) begin
                    if_inst = inst_rdata;
                end else begin
                    if_inst = 32'h0000_0000;
                end
            end
            ST_HOLD: begin
                if_inst = buf_r;
            end
            ST_DRAIN: begin
                inst_req    = 1'b1;
                inst_addr   = drain_addr_r;
                stallreq_if = 1'b1;
            end
            default: begin
                inst_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic, all checked against a
// transaction-level model (outstanding/killed/held request plus a redirect queue).
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        flush;
    logic [31:0] new_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit          m_started, m_killed, m_held;
    logic [31:0] m_pc, m_kill_addr, m_word;
    logic [31:0] m_redir[$];

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
        .flush(flush), .new_pc(new_pc),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void advance();
        if (m_redir.size() > 0) m_pc = m_redir.pop_front();
        else m_pc = m_pc + PC_STEP;
    endfunction

    // Memory answering with addr+0x100 for the directed part.
    task automatic mem(input logic ready);
        inst_ready = ready;
        inst_rdata = inst_addr + 32'h0000_0100;
        #1;
    endtask

    // Compare the current cycle against the model, then clock the model.
    task automatic step();
        logic        e_req, e_stallreq, addr_known;
        logic [31:0] e_addr, e_inst, old_pc;
        #2;
        if (!m_started) begin
            e_req = 1'b0; e_addr = m_pc; e_inst = 32'h0; e_stallreq = 1'b0; addr_known = 1'b1;
        end else if (m_killed) begin
            e_req = 1'b1; e_addr = m_kill_addr; e_inst = 32'h0; e_stallreq = 1'b1; addr_known = 1'b1;
        end else if (m_held) begin
            e_req = 1'b0; e_addr = 32'h0; e_inst = m_word; e_stallreq = 1'b0; addr_known = 1'b0;
        end else begin
            e_req = 1'b1; e_addr = m_pc; e_stallreq = ~inst_ready; addr_known = 1'b1;
            e_inst = (inst_ready && !flush) ? inst_rdata : 32'h0;
        end
        check("m_if_pc", if_pc, m_pc);
        check("m_inst_req", 32'(inst_req), 32'(e_req));
        check("m_if_inst", if_inst, e_inst);
        check("m_stallreq", 32'(stallreq_if), 32'(e_stallreq));
        if (addr_known) check("m_inst_addr", inst_addr, e_addr);
        @(posedge clk);
        if (!rst) begin
            m_started = 1'b0; m_killed = 1'b0; m_held = 1'b0; m_pc = RESET_PC; m_redir.delete();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else begin
            if (branch_flag_i && !flush) begin
                m_redir.delete();
                m_redir.push_back({branch_target_address_i[31:2], 2'b00});
            end
            if (flush) begin
                old_pc = m_pc;
                m_pc = {new_pc[31:2], 2'b00};
                m_redir.delete();
                if (m_held) m_held = 1'b0;
                else if (m_killed) m_killed = !inst_ready;
                else if (!inst_ready) begin m_killed = 1'b1; m_kill_addr = old_pc; end
            end else if (m_killed) begin
                m_killed = !inst_ready;
            end else if (m_held) begin
                if (!stall[0]) begin m_held = 1'b0; advance(); end
            end else if (inst_ready) begin
                if (stall[0]) begin m_held = 1'b1; m_word = inst_rdata; end
                else advance();
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 6'h0; branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        flush = 1'b0; new_pc = 32'h0; inst_ready = 1'b0; inst_rdata = 32'h0;
        m_started = 1'b0; m_killed = 1'b0; m_held = 1'b0; m_pc = RESET_PC;
        m_kill_addr = 32'h0; m_word = 32'h0;
        @(posedge clk); #1;
        check("rst_req", 32'(inst_req), 32'h0);
        check("rst_addr", inst_addr, RESET_PC);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_stallreq", 32'(stallreq_if), 32'h0);
        step();

        // Release reset: one RST cycle, then zero-wait fetches 0,4
        rst = 1'b1;
        mem(1'b1); check("rst_cycle_req", 32'(inst_req), 32'h0); step();
        for (int i = 0; i < 2; i++) begin
            mem(1'b1);
            check("zw_addr", inst_addr, 32'(i * 4));
            check("zw_inst", if_inst, 32'h100 + 32'(i * 4));
            check("zw_stallreq", 32'(stallreq_if), 32'h0);
            step();
        end

        // Two wait states at 0x8
        for (int w = 0; w < 3; w++) begin
            mem(w == 2);
            check("ws_addr", inst_addr, 32'h8);
            check("ws_req", 32'(inst_req), 32'h1);
            check("ws_stallreq", 32'(stallreq_if), (w == 2) ? 32'h0 : 32'h1);
            check("ws_inst", if_inst, (w == 2) ? 32'h108 : 32'h0);
            step();
        end
        mem(1'b1); check("zw_addr_c", inst_addr, 32'hC); step();

        // Branch to 0x40 (low bits masked) while the delay slot at 0x10 completes
        branch_flag_i = 1'b1; branch_target_address_i = 32'h0000_0042;
        mem(1'b1); check("br_slot_inst", if_inst, 32'h110); step();
        branch_flag_i = 1'b0;

        // Stall for three cycles at data return
        stall = 6'b000001;
        mem(1'b1); check("br_target_addr", inst_addr, 32'h40); check("st_inst0", if_inst, 32'h140); step();
        for (int k = 0; k < 2; k++) begin
            mem(1'b0);
            check("st_req", 32'(inst_req), 32'h0);
            check("st_inst", if_inst, 32'h140);
            step();
        end
        stall = 6'b000000;
        mem(1'b0); check("st_release_inst", if_inst, 32'h140); step();
        mem(1'b0); check("st_next_addr", inst_addr, 32'h44); step();

        // Flush to 0x180 during a wait
        flush = 1'b1; new_pc = 32'h0000_0180;
        mem(1'b0); step();
        flush = 1'b0;
        mem(1'b0); check("dr_addr", inst_addr, 32'h44); check("dr_stallreq", 32'(stallreq_if), 32'h1); step();
        mem(1'b1); check("dr_addr_rdy", inst_addr, 32'h44); check("dr_inst", if_inst, 32'h0); step();
        mem(1'b0); check("fl_new_addr", inst_addr, 32'h180); step();

        // Reset mid-wait, then wrap at the top of the address space
        rst = 1'b0;
        mem(1'b0); step();
        mem(1'b0); check("rw_req_drop", 32'(inst_req), 32'h0); check("rw_addr", inst_addr, RESET_PC);
        rst = 1'b1; step();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        mem(1'b1); check("rw_restart", inst_addr, RESET_PC); check("fl_drop_inst", if_inst, 32'h0); step();
        flush = 1'b0;
        mem(1'b1); check("wrap_hi", inst_addr, 32'hFFFF_FFFC); check("wrap_inst", if_inst, 32'h0000_00FC); step();
        mem(1'b1); check("wrap_zero", inst_addr, 32'h0); step();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            stall = 6'($urandom);
            stall[0] = ($urandom_range(99) < 30);
            branch_flag_i = ($urandom_range(99) < 15);
            branch_target_address_i = $urandom;
            flush = ($urandom_range(99) < 7);
            new_pc = $urandom;
            inst_ready = ($urandom_range(99) < 55);
            inst_rdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
